cp0_exc_seq: RTL and testbench
==============================

# cp0_exc_seq

Multi-cycle exception/ERET sequencer for the CP0 path of the multi-cycle MIPS CPU. It accepts a trap request (syscall/break/teq) or an ERET from the control unit, then walks the required CP0 writes one per cycle. For each write it drives the one-hot select strobes `MUXT_CP0_W_STATUS`, `MUXT_CP0_W_CAUSE` and `MUXT_CP0_W_EPC` into the CP0 write-address mux, plus the matching write data. It finishes with a PC redirect to the exception vector or to EPC.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'h0040_0004: PC target for a taken exception.
- `STATUS_SHIFT`, default 5: shift applied to STATUS on exception entry (left) and on ERET (right).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `EXC_REQ`, input, 1: trap request, sampled only in IDLE.
- `EXC_CODE`, input, 5: 8 = syscall, 9 = break, 13 = teq; sampled with `EXC_REQ`.
- `ERET_REQ`, input, 1: ERET request, sampled only in IDLE.
- `PC_CUR`, input, 32: address of the trapping instruction, captured at accept.
- `STATUS_RDATA`, input, 32: current CP0 STATUS, captured at accept.
- `EPC_RDATA`, input, 32: current CP0 EPC, captured at ERET accept.
- `MUXT_CP0_W_STATUS`, `MUXT_CP0_W_CAUSE`, `MUXT_CP0_W_EPC`, output, 1 each: write-address selects; at most one is high in any cycle.
- `CP0_WE`, output, 1: CP0 write enable.
- `CP0_WDATA`, output, 32: CP0 write data.
- `PC_REDIRECT`, output, 1: one-cycle pulse that loads `PC_REDIRECT_ADDR` into the PC.
- `PC_REDIRECT_ADDR`, output, 32: redirect target.
- `BUSY`, output, 1: high in every non-IDLE state; the control unit stalls while it is high.
- `EXC_DROP`, output, 1: one-cycle pulse when a request is masked and discarded.

## Operation
- States: `IDLE`, `X_STATUS`, `X_CAUSE`, `X_EPC`, `X_REDIR`, `E_STATUS`, `E_REDIR`.
- All outputs are Moore, decoded from the state and the capture registers only.

Accept in IDLE:
- Mask check:
  - `STATUS_RDATA[0]` is the global enable.
  - Per-code enables: bit1 = syscall, bit2 = break, bit3 = teq.
  - Any other code needs only bit0.
- A request is taken only when both the global enable and its per-code enable are set.
- `EXC_REQ` and taken: capture code, `PC_CUR` and `STATUS_RDATA`, then go to `X_STATUS`.
- `EXC_REQ` and masked: stay in IDLE, set `EXC_DROP` for the next cycle, make no CP0 writes.
- `ERET_REQ` only: capture `STATUS_RDATA` and `EPC_RDATA`, then go to `E_STATUS`.
- `EXC_REQ` and `ERET_REQ` together: the exception wins and ERET is discarded.

Per-state outputs (`CP0_WE` = 1 in every write state):
- `X_STATUS`: STATUS strobe; WDATA = captured STATUS << `STATUS_SHIFT`.
- `X_CAUSE`: CAUSE strobe; WDATA = {25'b0, code, 2'b00}.
- `X_EPC`: EPC strobe; WDATA = captured PC.
- `X_REDIR`: `PC_REDIRECT` = 1, ADDR = `EXC_VECTOR`; next state IDLE.
- `E_STATUS`: STATUS strobe; WDATA = captured STATUS >> `STATUS_SHIFT` (logical shift).
- `E_REDIR`: `PC_REDIRECT` = 1, ADDR = captured EPC; next state IDLE.

Request handling and idle outputs:
- Requests arriving outside IDLE are ignored; they are not queued.
- In IDLE and at reset, every output is 0, including the 32-bit outputs.
- `CP0_WDATA` is 0 whenever `CP0_WE` = 0.

## Timing
- Exception accepted at edge t:
  - `X_STATUS` during cycle t+1, `X_CAUSE` t+2, `X_EPC` t+3, `X_REDIR` t+4.
  - Back in IDLE at t+5, where a new request can be sampled.
- ERET accepted at edge t: `E_STATUS` at t+1, `E_REDIR` at t+2, IDLE at t+3.
- Masked request at edge t: `EXC_DROP` high for cycle t+1 only, and `BUSY` stays 0.
- Captured values are frozen for the whole sequence. A change on `STATUS_RDATA` after the `X_STATUS` write does not affect later states.
- `rst_n` low at any point, including mid-sequence:
  - State goes to IDLE immediately.
  - Capture registers and all outputs go to 0.
  - The partial sequence is not resumed.

## Structure
- Shared package `cp0_pkg`:
  - Exception codes: `EXC_SYSCALL` = 8, `EXC_BREAK` = 9, `EXC_TEQ` = 13.
  - STATUS bit indices: IE = 0, SYS = 1, BRK = 2, TEQ = 3.
  - CP0 register numbers: STATUS = 12, CAUSE = 13, EPC = 14.
  - The state encoding.
- One sub-module, `cp0_exc_mask`: combinational code + STATUS → `take`.
- The FSM, capture registers and output decode all live in `cp0_exc_seq`.

## Test plan
- Syscall taken: `EXC_REQ`, code 8, STATUS = 0x0000000F, PC = 0x00400020.
  - Writes in order: STATUS 0x000001E0, CAUSE 0x00000020, EPC 0x00400020, one strobe per cycle.
  - Redirect to 0x00400004 at t+4; `BUSY` high for cycles t+1 to t+4.
- Break masked: code 9, STATUS = 0x0000000B.
  - No `CP0_WE`, no strobe, `BUSY` stays 0.
  - `EXC_DROP` pulses at t+1.
- ERET: STATUS = 0x000001E0, EPC = 0x00400020.
  - STATUS write 0x0000000F at t+1.
  - `PC_REDIRECT` to 0x00400020 at t+2.
- Simultaneous teq (code 13, STATUS = 0x0F) and ERET:
  - Full exception sequence runs with CAUSE 0x00000034.
  - No ERET redirect follows.
- Busy and reset:
  - Second `EXC_REQ` during `X_CAUSE` is ignored, and exactly one sequence completes.
  - A separate run drops `rst_n` during `X_CAUSE`: outputs go to 0 asynchronously and the block restarts in IDLE with no EPC write.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, STATUS bit positions, register
// numbers and the exception/ERET sequencer state encoding.
package cp0_pkg;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_SYS = 1;
  localparam int unsigned ST_BRK = 2;
  localparam int unsigned ST_TEQ = 3;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic [2:0] {
    IDLE,
    X_STATUS,
    X_CAUSE,
    X_EPC,
    X_REDIR,
    E_STATUS,
    E_REDIR
  } exc_state_e;

endpackage

// File: rtl/cp0_exc_mask.sv
// Decides whether a trap request is taken: global enable plus the
// per-code enable; unknown codes need only the global enable.
module cp0_exc_mask
  import cp0_pkg::*;
(
  input  logic [4:0] code_i,
  input  logic [3:0] status_i,
  output logic       take_o
);

  logic code_en;

  always_comb begin
    unique case (code_i)
      EXC_SYSCALL: code_en = status_i[ST_SYS];
      EXC_BREAK:   code_en = status_i[ST_BRK];
      EXC_TEQ:     code_en = status_i[ST_TEQ];
      default:     code_en = 1'b1;
    endcase
  end

  assign take_o = status_i[ST_IE] & code_en;

endmodule

// File: rtl/cp0_exc_seq.sv
// CP0 exception/ERET sequencer: captures the request context in IDLE, then
// issues one CP0 write per cycle and finishes with a PC redirect.
module cp0_exc_seq
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
  parameter int unsigned STATUS_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EXC_REQ,
  input  logic [4:0]  EXC_CODE,
  input  logic        ERET_REQ,
  input  logic [31:0] PC_CUR,
  input  logic [31:0] STATUS_RDATA,
  input  logic [31:0] EPC_RDATA,
  output logic        MUXT_CP0_W_STATUS,
  output logic        MUXT_CP0_W_CAUSE,
  output logic        MUXT_CP0_W_EPC,
  output logic        CP0_WE,
  output logic [31:0] CP0_WDATA,
  output logic        PC_REDIRECT,
  output logic [31:0] PC_REDIRECT_ADDR,
  output logic        BUSY,
  output logic        EXC_DROP
);

  exc_state_e  state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic        drop_q, drop_d;
  logic        take;

  cp0_exc_mask u_mask (
    .code_i   (EXC_CODE),
    .status_i (STATUS_RDATA[3:0]),
    .take_o   (take)
  );

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case statement leaves one unassigned (no latches).
    state_d  = state_q;
    code_d   = code_q;
    pc_d     = pc_q;
    status_d = status_q;
    epc_d    = epc_q;
    drop_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (EXC_REQ) begin
          // A simultaneous ERET is discarded even when the trap is masked.
          if (take) begin
            code_d   = EXC_CODE;
            pc_d     = PC_CUR;
            status_d = STATUS_RDATA;
            state_d  = X_STATUS;
          end else begin
            drop_d = 1'b1;
          end
        end else if (ERET_REQ) begin
          status_d = STATUS_RDATA;
          epc_d    = EPC_RDATA;
          state_d  = E_STATUS;
        end
      end
      X_STATUS: state_d = X_CAUSE;
      X_CAUSE:  state_d = X_EPC;
      X_EPC:    state_d = X_REDIR;
      X_REDIR:  state_d = IDLE;
      E_STATUS: state_d = E_REDIR;
      E_REDIR:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: the capture registers are reset too, so an aborted sequence
  // leaves no stale context behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      pc_q     <= '0;
      status_q <= '0;
      epc_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from
      // the same pre-edge values.
      state_q  <= state_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      status_q <= status_d;
      epc_q    <= epc_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    MUXT_CP0_W_STATUS = 1'b0;
    MUXT_CP0_W_CAUSE  = 1'b0;
    MUXT_CP0_W_EPC    = 1'b0;
    CP0_WE            = 1'b0;
    CP0_WDATA         = '0;
    PC_REDIRECT       = 1'b0;
    PC_REDIRECT_ADDR  = '0;
    BUSY              = (state_q != IDLE);
    EXC_DROP          = drop_q;

    unique case (state_q)
      X_STATUS: begin
        MUXT_CP0_W_STATUS = 1'b1;
        CP0_WE            = 1'b1;
        CP0_WDATA         = status_q << STATUS_SHIFT;
      end
      X_CAUSE: begin
        MUXT_CP0_W_CAUSE = 1'b1;
        CP0_WE           = 1'b1;
        CP0_WDATA        = {25'b0, code_q, 2'b00};
      end
      X_EPC: begin
        MUXT_CP0_W_EPC = 1'b1;
        CP0_WE         = 1'b1;
        CP0_WDATA      = pc_q;
      end
      X_REDIR: begin
        PC_REDIRECT      = 1'b1;
        PC_REDIRECT_ADDR = EXC_VECTOR;
      end
      E_STATUS: begin
        MUXT_CP0_W_STATUS = 1'b1;
        CP0_WE            = 1'b1;
        CP0_WDATA         = status_q >> STATUS_SHIFT;
      end
      E_REDIR: begin
        PC_REDIRECT      = 1'b1;
        PC_REDIRECT_ADDR = epc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Self-checking bench for cp0_exc_seq: a schedule-of-expected-cycles model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cp0_exc_seq;

  typedef struct packed {
    logic        s_status;
    logic        s_cause;
    logic        s_epc;
    logic        we;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] raddr;
    logic        busy;
    logic        drop;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EXC_REQ, ERET_REQ;
  logic [4:0]  EXC_CODE;
  logic [31:0] PC_CUR, STATUS_RDATA, EPC_RDATA;
  logic        MUXT_CP0_W_STATUS, MUXT_CP0_W_CAUSE, MUXT_CP0_W_EPC;
  logic        CP0_WE, PC_REDIRECT, BUSY, EXC_DROP;
  logic [31:0] CP0_WDATA, PC_REDIRECT_ADDR;

  int n_checks = 0;
  int n_errors = 0;

  out_t cur;
  out_t sched[$];

  cp0_exc_seq dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .EXC_REQ           (EXC_REQ),
    .EXC_CODE          (EXC_CODE),
    .ERET_REQ          (ERET_REQ),
    .PC_CUR            (PC_CUR),
    .STATUS_RDATA      (STATUS_RDATA),
    .EPC_RDATA         (EPC_RDATA),
    .MUXT_CP0_W_STATUS (MUXT_CP0_W_STATUS),
    .MUXT_CP0_W_CAUSE  (MUXT_CP0_W_CAUSE),
    .MUXT_CP0_W_EPC    (MUXT_CP0_W_EPC),
    .CP0_WE            (CP0_WE),
    .CP0_WDATA         (CP0_WDATA),
    .PC_REDIRECT       (PC_REDIRECT),
    .PC_REDIRECT_ADDR  (PC_REDIRECT_ADDR),
    .BUSY              (BUSY),
    .EXC_DROP          (EXC_DROP)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    out_t o;
    o.s_status = MUXT_CP0_W_STATUS;
    o.s_cause  = MUXT_CP0_W_CAUSE;
    o.s_epc    = MUXT_CP0_W_EPC;
    o.we       = CP0_WE;
    o.wdata    = CP0_WDATA;
    o.redir    = PC_REDIRECT;
    o.raddr    = PC_REDIRECT_ADDR;
    o.busy     = BUSY;
    o.drop     = EXC_DROP;
    return o;
  endfunction

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Trap rule: global enable bit 0, plus bit 1/2/3 for codes 8/9/13.
  function automatic bit trap_taken(input logic [4:0] code, input logic [31:0] st);
    if (!st[0]) return 1'b0;
    if (code == 5'd8)  return st[1];
    if (code == 5'd9)  return st[2];
    if (code == 5'd13) return st[3];
    return 1'b1;
  endfunction

  // Called right after a rising edge with the inputs that edge sampled;
  // 'cur' becomes the expected output for the cycle that edge starts.
  task automatic model_edge();
    out_t r;
    if (!rst_n) begin
      cur = '0;
      sched.delete();
      return;
    end
    if (!cur.busy && EXC_REQ) begin
      if (trap_taken(EXC_CODE, STATUS_RDATA)) begin
        r = '0; r.busy = 1; r.we = 1; r.s_status = 1; r.wdata = STATUS_RDATA * 32;
        sched.push_back(r);
        r = '0; r.busy = 1; r.we = 1; r.s_cause = 1; r.wdata = 32'(EXC_CODE) * 4;
        sched.push_back(r);
        r = '0; r.busy = 1; r.we = 1; r.s_epc = 1; r.wdata = PC_CUR;
        sched.push_back(r);
        r = '0; r.busy = 1; r.redir = 1; r.raddr = 32'h0040_0004;
        sched.push_back(r);
      end else begin
        r = '0; r.drop = 1;
        sched.push_back(r);
      end
    end else if (!cur.busy && ERET_REQ) begin
      r = '0; r.busy = 1; r.we = 1; r.s_status = 1; r.wdata = STATUS_RDATA / 32;
      sched.push_back(r);
      r = '0; r.busy = 1; r.redir = 1; r.raddr = EPC_RDATA;
      sched.push_back(r);
    end
    cur = (sched.size() != 0) ? sched.pop_front() : '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle_outputs", dut_out(), cur);
  endtask

  task automatic quiet();
    EXC_REQ = 0; ERET_REQ = 0; EXC_CODE = '0;
    PC_CUR = '0; STATUS_RDATA = '0; EPC_RDATA = '0;
  endtask

  task automatic async_reset();
    rst_n = 0;
    #1;
    check("async_reset_outputs", dut_out(), '0);
    cur = '0;
    sched.delete();
  endtask

  initial begin
    cur = '0;
    quiet();
    rst_n = 0;
    #2;
    check("reset_outputs", dut_out(), '0);
    step();
    #2 rst_n = 1;
    step();

    // Syscall taken; STATUS change after accept must not leak in.
    EXC_REQ = 1; EXC_CODE = 5'd8; STATUS_RDATA = 32'h0000_000F; PC_CUR = 32'h0040_0020;
    step();
    check("sys_status_wdata", {39'd0, CP0_WDATA}, {39'd0, 32'h0000_01E0});
    check("sys_status_strobe", {68'd0, MUXT_CP0_W_STATUS, CP0_WE, BUSY}, 71'b111);
    quiet(); STATUS_RDATA = 32'hFFFF_0000;
    step();
    check("sys_cause_wdata", {39'd0, CP0_WDATA}, {39'd0, 32'h0000_0020});
    step();
    check("sys_epc_wdata", {39'd0, CP0_WDATA}, {39'd0, 32'h0040_0020});
    step();
    check("sys_redirect", {38'd0, PC_REDIRECT, PC_REDIRECT_ADDR}, {38'd1, 32'h0040_0004});
    step();
    check("sys_back_idle", {70'd0, BUSY}, 71'd0);

    // Break masked.
    EXC_REQ = 1; EXC_CODE = 5'd9; STATUS_RDATA = 32'h0000_000B;
    step();
    check("brk_drop", {68'd0, EXC_DROP, BUSY, CP0_WE}, 71'b100);
    quiet();
    step();
    check("brk_drop_one_cycle", {70'd0, EXC_DROP}, 71'd0);

    // ERET.
    ERET_REQ = 1; STATUS_RDATA = 32'h0000_01E0; EPC_RDATA = 32'h0040_0020;
    step();
    check("eret_status_wdata", {39'd0, CP0_WDATA}, {39'd0, 32'h0000_000F});
    quiet();
    step();
    check("eret_redirect", {38'd0, PC_REDIRECT, PC_REDIRECT_ADDR}, {38'd1, 32'h0040_0020});
    step();

    // TEQ together with ERET: exception wins.
    EXC_REQ = 1; ERET_REQ = 1; EXC_CODE = 5'd13; STATUS_RDATA = 32'h0000_000F;
    PC_CUR = 32'h0040_0100; EPC_RDATA = 32'h1234_5678;
    step();
    quiet();
    step();
    check("teq_cause_wdata", {39'd0, CP0_WDATA}, {39'd0, 32'h0000_0034});
    step();
    step();
    check("teq_redirect_vector", {38'd0, PC_REDIRECT, PC_REDIRECT_ADDR}, {38'd1, 32'h0040_0004});
    step();
    step();
    check("teq_no_eret_redirect", {70'd0, PC_REDIRECT}, 71'd0);

    // Second request during X_CAUSE is ignored.
    EXC_REQ = 1; EXC_CODE = 5'd8; STATUS_RDATA = 32'h0000_000F; PC_CUR = 32'h0040_0200;
    step();
    quiet();
    step();
    EXC_REQ = 1; EXC_CODE = 5'd9; STATUS_RDATA = 32'h0000_000F;
    step();
    quiet();
    step();
    step();
    check("busy_second_ignored", {70'd0, BUSY}, 71'd0);
    step();
    check("busy_no_second_seq", {70'd0, BUSY}, 71'd0);

    // Reset during X_CAUSE.
    EXC_REQ = 1; EXC_CODE = 5'd8; STATUS_RDATA = 32'h0000_000F; PC_CUR = 32'h0040_0300;
    step();
    quiet();
    step();
    async_reset();
    step();
    #2 rst_n = 1;
    step();
    check("reset_no_epc_write", {69'd0, MUXT_CP0_W_EPC, CP0_WE}, 71'd0);
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      EXC_REQ  = ($urandom_range(0, 4) == 0);
      ERET_REQ = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: EXC_CODE = 5'd8;
        1: EXC_CODE = 5'd9;
        2: EXC_CODE = 5'd13;
        default: EXC_CODE = 5'($urandom);
      endcase
      STATUS_RDATA = $urandom;
      if ($urandom_range(0, 1) == 0) STATUS_RDATA[3:0] = 4'hF;
      PC_CUR    = $urandom;
      EPC_RDATA = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        step();
        #2 rst_n = 1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
